// File: rtl/fc_arbiter.sv
// fc_arbiter: 4-channel source-FIFO read arbiter with pause/halt flow control and a two-stage forward path.
// Optional macro FC_ARB_PRIORITY_EN selects fixed priority (channel 0 highest) in place of round-robin.
module fc_arbiter #(
    parameter int DATA_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            pause,
    input  logic [3:0]            i_continue,
    input  logic [3:0]            error_full,
    input  logic                  idle,
    input  logic [3:0]            FIFOempty,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic [DATA_WIDTH-1:0] data1,
    input  logic [DATA_WIDTH-1:0] data2,
    input  logic [DATA_WIDTH-1:0] data3,
    input  logic                  out_ready,
    output logic [3:0]            pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [1:0]            chan_out,
    output logic [3:0]            halted
);

    typedef enum logic [1:0] {sIDLE, sARB, sWAIT} state_t;

    state_t                r_state, w_next;
    logic [3:0]            r_paused, r_halted, w_elig;
    logic                  w_any, w_pop_en;
    logic [1:0]            w_gidx, r_p1_chan, r_chan_out;
    logic [1:0]            r_vld_pipe;
    logic [DATA_WIDTH-1:0] w_rdata, r_data_out;

    // Flags are registered, so a pause/halt landing with a pop never cancels it.
    assign w_elig = ~FIFOempty & ~r_paused & ~r_halted;
    assign w_any  = |w_elig;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_paused <= 4'b0000;
            r_halted <= 4'b0000;
        end else begin
            r_paused <= (r_paused & ~i_continue) | pause;
            r_halted <= r_halted | error_full;
        end
    end

`ifdef FC_ARB_PRIORITY_EN
    always_comb begin
        w_gidx = 2'd0;
        for (int k = 3; k >= 0; k--)
            if (w_elig[k]) w_gidx = 2'(k);
    end
`else
    logic [1:0] r_ptr;

    // Descending scan so the channel closest after r_ptr wins; k=4 wraps to r_ptr itself.
    always_comb begin
        w_gidx = r_ptr;
        for (int k = 4; k >= 1; k--)
            if (w_elig[r_ptr + 2'(k)]) w_gidx = r_ptr + 2'(k);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        r_ptr <= 2'd3;
        else if (w_pop_en) r_ptr <= w_gidx;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= sIDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_pop_en = 1'b0;
        case (r_state)
            sIDLE: if (!idle) w_next = sARB;
            sARB: begin
                if (idle)           w_next = sIDLE;
                else if (!w_any)    w_next = sWAIT;
                else if (out_ready) w_pop_en = 1'b1;
            end
            sWAIT: begin
                if (idle)       w_next = sIDLE;
                else if (w_any) w_next = sARB;
            end
            default: w_next = sIDLE;
        endcase
    end

    assign pop = w_pop_en ? (4'b0001 << w_gidx) : 4'b0000;

    always_comb begin
        case (r_p1_chan)
            2'd0:    w_rdata = data0;
            2'd1:    w_rdata = data1;
            2'd2:    w_rdata = data2;
            default: w_rdata = data3;
        endcase
    end

    // Stage 0: pop issued; stage 1: FIFO data captured into the output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld_pipe <= 2'b00;
            r_p1_chan  <= 2'd0;
            r_data_out <= '0;
            r_chan_out <= 2'd0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], w_pop_en};
            if (w_pop_en) r_p1_chan <= w_gidx;
            if (r_vld_pipe[0]) begin
                r_data_out <= w_rdata;
                r_chan_out <= r_p1_chan;
            end
        end
    end

    assign data_out  = r_data_out;
    assign valid_out = r_vld_pipe[1];
    assign chan_out  = r_chan_out;
    assign halted    = r_halted;

endmodule

// File: tb/tb_fc_arbiter.sv
// Directed bench for fc_arbiter: round-robin order, pause/continue, halt, out_ready backpressure, mid-transfer reset.
module tb_fc_arbiter;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          reset, idle, out_ready, valid_out;
    logic [3:0]    pause, i_continue, error_full, FIFOempty, pop, halted;
    logic [DW-1:0] dv [4] = '{10'h155, 10'h0A1, 10'h2B2, 10'h3C3};
    logic [DW-1:0] data_out;
    logic [1:0]    chan_out;
    int            n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    fc_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .pause(pause), .i_continue(i_continue),
        .error_full(error_full), .idle(idle), .FIFOempty(FIFOempty),
        .data0(dv[0]), .data1(dv[1]), .data2(dv[2]), .data3(dv[3]),
        .out_ready(out_ready), .pop(pop), .data_out(data_out),
        .valid_out(valid_out), .chan_out(chan_out), .halted(halted)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".pop"}, 32'(pop), 0);
        chk({tag, ".valid"}, 32'(valid_out), 0);
        chk({tag, ".data"}, 32'(data_out), 0);
        chk({tag, ".chan"}, 32'(chan_out), 0);
        chk({tag, ".halted"}, 32'(halted), 0);
    endtask

    // After this returns, the next posedge (P1) moves sIDLE->sARB; cycle 1 carries the first pop.
    task automatic start();
        reset = 1'b0; pause = 0; i_continue = 0; error_full = 0;
        idle = 1'b0; FIFOempty = 4'b0000; out_ready = 1'b1;
        @(posedge clk); #1; @(posedge clk); #1;
        chk_zero("rst");
        reset = 1'b1;
        #1 chk("idle_state.pop", 32'(pop), 0);
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0] e [1:9];

        // Round-robin from channel 0 with full FIFOs
        start();
        e[1:8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int c = 1; c <= 8; c++) begin
            cyc(); #1;
            chk($sformatf("rr.pop%0d", c), 32'(pop), 32'(e[c]));
            if (c >= 3) begin
                chk($sformatf("rr.vld%0d", c), 32'(valid_out), 1);
                chk($sformatf("rr.chan%0d", c), 32'(chan_out), 32'((c - 3) % 4));
                chk($sformatf("rr.data%0d", c), 32'(data_out), 32'(dv[(c - 3) % 4]));
            end else
                chk($sformatf("rr.vld%0d", c), 32'(valid_out), 0);
        end
        cyc(); idle = 1'b1; #1;
        chk("idle_in_arb.pop", 32'(pop), 0);

        // Pause ch1 in cycle 1, continue in cycle 6
        start();
        e = '{4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
        for (int c = 1; c <= 9; c++) begin
            cyc();
            pause      = (c == 1) ? 4'b0010 : 4'b0000;
            i_continue = (c == 6) ? 4'b0010 : 4'b0000;
            #1 chk($sformatf("pause.pop%0d", c), 32'(pop), 32'(e[c]));
        end

        // Pause and continue together on ch2: pause wins
        start();
        e[1:6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        for (int c = 1; c <= 6; c++) begin
            cyc();
            pause      = (c == 1) ? 4'b0100 : 4'b0000;
            i_continue = (c == 1) ? 4'b0100 : 4'b0000;
            #1 chk($sformatf("both.pop%0d", c), 32'(pop), 32'(e[c]));
        end

        // Halt ch3, continue does not clear it
        start();
        e[1:6] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100};
        for (int c = 1; c <= 6; c++) begin
            cyc();
            error_full = (c == 1) ? 4'b1000 : 4'b0000;
            i_continue = (c == 3) ? 4'b1000 : 4'b0000;
            #1 chk($sformatf("halt.pop%0d", c), 32'(pop), 32'(e[c]));
            if (c == 2 || c == 6) chk($sformatf("halt.halted%0d", c), 32'(halted), 32'h8);
        end

        // Backpressure after one pop of ch0
        start();
        cyc(); #1 chk("bp.pop1", 32'(pop), 32'h1);
        cyc(); out_ready = 1'b0; #1;
        chk("bp.pop2", 32'(pop), 0);
        chk("bp.vld2", 32'(valid_out), 0);
        cyc(); #1;
        chk("bp.pop3", 32'(pop), 0);
        chk("bp.vld3", 32'(valid_out), 1);
        chk("bp.data3", 32'(data_out), 32'h155);
        chk("bp.chan3", 32'(chan_out), 0);
        cyc(); #1;
        chk("bp.pop4", 32'(pop), 0);
        chk("bp.vld4", 32'(valid_out), 0);
        chk("bp.hold4", 32'(data_out), 32'h155);

        // One-cycle reset right after a pop discards the in-flight word
        start();
        cyc(); #1 chk("mrst.pop1", 32'(pop), 32'h1);
        cyc(); reset = 1'b0; #1;
        chk_zero("mrst.in");
        cyc(); reset = 1'b1; #1;
        chk("mrst.vld3", 32'(valid_out), 0);
        chk("mrst.pop3", 32'(pop), 0);
        cyc(); #1;
        chk("mrst.vld4", 32'(valid_out), 0);
        chk("mrst.pop4", 32'(pop), 32'h1);
        cyc(); #1;
        chk("mrst.vld5", 32'(valid_out), 0);
        chk("mrst.pop5", 32'(pop), 32'h2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/fc_arbiter.md
FC_ARBITER -- requirements
Module: fc_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 10, the width of one FIFO word.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port pause, input, 4 bits: per-channel pause pulse from the flow-control FSM.
REQ-005 The block SHALL have port continue, input, 4 bits: per-channel continue pulse from the flow-control FSM.
REQ-006 The block SHALL have port error_full, input, 4 bits: per-channel error indication from the flow-control FSM.
REQ-007 The block SHALL have port idle, input, 1 bit: flow-control FSM idle; while high, no pops are issued.
REQ-008 The block SHALL have port FIFOempty, input, 4 bits: per-channel source FIFO empty flag.
REQ-009 The block SHALL have ports data0..data3, input, DATA_WIDTH each: source FIFO read data, valid the cycle after the matching pop.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream can accept a word.
REQ-011 The block SHALL have port pop, output, 4 bits: one-hot FIFO read strobe.
REQ-012 The block SHALL have port data_out, output, DATA_WIDTH: forwarded word.
REQ-013 The block SHALL have port valid_out, output, 1 bit: data_out valid, single-cycle per word.
REQ-014 The block SHALL have port chan_out, output, 2 bits: source channel of data_out.
REQ-015 The block SHALL have port halted, output, 4 bits: per-channel error-disabled status.

Function
REQ-016 The block SHALL keep a per-channel paused bit: set when pause[i] is high, cleared when continue[i] is high; if both are high in the same cycle, pause wins.
REQ-017 The block SHALL set halted[i] when error_full[i] is high and hold it until reset; continue SHALL NOT clear it.
REQ-018 Channel i SHALL be eligible when FIFOempty[i]=0, paused[i]=0 and halted[i]=0, using the registered flag values.
REQ-019 The state machine SHALL have states sIDLE, sARB and sWAIT.
REQ-020 sIDLE SHALL move to sARB when idle=0.
REQ-021 sARB SHALL issue a pop when out_ready=1 and at least one channel is eligible; if idle=1 it SHALL return to sIDLE.
REQ-022 sARB SHALL move to sWAIT when no channel is eligible.
REQ-023 sWAIT SHALL return to sARB when any channel is eligible, or to sIDLE when idle=1.
REQ-024 Round-robin grant: search starts at last granted channel+1, modulo 4; pointer resets to 3 so channel 0 is served first.
REQ-025 The block SHALL assert at most one pop bit per cycle, for one cycle per grant; back-to-back grants in consecutive cycles are allowed.
REQ-026 A pause[i] or halt arriving in the same cycle as a pop of channel i SHALL NOT cancel that pop; the channel SHALL be excluded from the next cycle onward.
REQ-027 Latency: pop in cycle N, FIFO data sampled in N+1, and data_out/valid_out/chan_out registered and visible in N+2.
REQ-028 valid_out SHALL be high for exactly one cycle per pop; data_out SHALL hold its last value when valid_out=0.
REQ-029 out_ready low SHALL block new pops only; words already in flight SHALL still be delivered.

Reset
REQ-030 While reset=0: pop=0, valid_out=0, data_out=0, chan_out=0, halted=0, paused=0, state=sIDLE, pointer=3.
REQ-031 Reset asserted mid-transfer SHALL discard any in-flight word; no valid_out SHALL follow the deassertion of reset.

Configuration
REQ-032 With FC_ARB_PRIORITY_EN defined, grant SHALL use fixed priority (channel 0 highest) and the round-robin pointer SHALL be removed.
REQ-033 Without FC_ARB_PRIORITY_EN, the round-robin policy of REQ-024 SHALL apply.

Verification
REQ-034 Reset, idle=0, all FIFOs non-empty, out_ready=1 -> pop sequence 0001,0010,0100,1000,0001 on consecutive cycles; chan_out 0,1,2,3 starting two cycles after the first pop.
REQ-035 Pulse pause=0010, then continue=0010 five cycles later -> channel 1 not popped in between; channel 1 is popped again on its next round-robin slot after the continue.
REQ-036 pause=0100 and continue=0100 in the same cycle -> channel 2 stays paused.
REQ-037 error_full=1000, then continue=1000 -> halted=1000 persists and channel 3 is never popped until reset.
REQ-038 Pop of channel 0 with data0=10'h155, then out_ready=0 -> data_out=10'h155 and valid_out=1 two cycles after the pop, with no further pops while out_ready=0.
REQ-039 reset=0 for one cycle, asserted one cycle after a pop -> no valid_out follows, all outputs are 0, and arbitration restarts at channel 0.
